// File: rtl/pwm_dac.sv
// Audio PWM DAC: scales and saturates filtered samples, double-buffers the duty,
// and emits a registered PWM waveform whose duty changes only at period boundaries.
module pwm_dac #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ready_in,
  input  logic [15:0] signal_in,
  input  logic [2:0]  gain_shift_in,
  output logic        pwm_out,
  output logic        period_start_out,
  output logic        sat_out,
  output logic [7:0]  overrun_count_out
);

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned SCALE_W    = 24;
  localparam int unsigned DUTY_SHIFT = SAMPLE_W - PWM_BITS;

  localparam logic [PWM_BITS-1:0] DUTY_MID = {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
  localparam logic [7:0]          OVR_MAX  = 8'hFF;

  logic [PWM_BITS-1:0]       cnt;
  logic [PWM_BITS-1:0]       active_duty;
  logic [PWM_BITS-1:0]       pending_duty;
  logic                      pending_valid;
  logic                      s1_valid;
  logic [SAMPLE_W-1:0]       sat_q;

  logic signed [SCALE_W-1:0] scaled_c;
  logic [SAMPLE_W-1:0]       sat_c;
  logic                      clip_c;
  logic [PWM_BITS-1:0]       duty_c;
  logic                      cnt_wrap_c;

  // Sign-extend, apply gain, clamp into the 16-bit signed range
  always_comb begin
    scaled_c = $signed({{(SCALE_W-SAMPLE_W){signal_in[SAMPLE_W-1]}}, signal_in}) <<< gain_shift_in;
    sat_c    = scaled_c[SAMPLE_W-1:0];
    clip_c   = 1'b0;
    if (scaled_c > 24'sd32767) begin
      sat_c  = 16'h7FFF;
      clip_c = 1'b1;
    end else if (scaled_c < -24'sd32768) begin
      sat_c  = 16'h8000;
      clip_c = 1'b1;
    end
  end

  // Offset binary: flipping the sign bit maps -32768..32767 onto 0..65535
  always_comb begin
    duty_c     = PWM_BITS'((sat_q ^ 16'h8000) >> DUTY_SHIFT);
    cnt_wrap_c = (cnt == CNT_MAX);
  end

  // Stage 1: capture saturated sample
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sat_q    <= '0;
      s1_valid <= 1'b0;
      sat_out  <= 1'b0;
    end else begin
      s1_valid <= ready_in;
      sat_out  <= ready_in & clip_c;
      if (ready_in) begin
        sat_q <= sat_c;
      end
    end
  end

  // Stage 2 and duty double buffer; a write on the wrap edge is never an overrun
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pending_duty      <= DUTY_MID;
      pending_valid     <= 1'b0;
      active_duty       <= DUTY_MID;
      overrun_count_out <= '0;
    end else begin
      if (s1_valid) begin
        pending_duty <= duty_c;
      end
      pending_valid <= s1_valid | (pending_valid & ~cnt_wrap_c);
      if (cnt_wrap_c && pending_valid) begin
        active_duty <= pending_duty;
      end
      if (s1_valid && pending_valid && !cnt_wrap_c && (overrun_count_out != OVR_MAX)) begin
        overrun_count_out <= overrun_count_out + 8'd1;
      end
    end
  end

  // Free-running period counter and registered comparator
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt + PWM_BITS'(1);
      pwm_out <= (cnt < active_duty);
    end
  end

  assign period_start_out = (cnt == '0);

endmodule

// File: tb/tb_pwm_dac.sv
// Randomized scoreboard bench for pwm_dac: per-period high counts, sat pulses and
// overrun counts are checked against an event-level model of sample write times.
module tb_pwm_dac;

  localparam int unsigned PWM_BITS = 8;
  localparam int unsigned PERIOD   = 256;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        ready_in = 1'b0;
  logic [15:0] signal_in = '0;
  logic [2:0]  gain_shift_in = '0;
  logic        pwm_out;
  logic        period_start_out;
  logic        sat_out;
  logic [7:0]  overrun_count_out;

  pwm_dac #(.PWM_BITS(PWM_BITS)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .ready_in          (ready_in),
    .signal_in         (signal_in),
    .gain_shift_in     (gain_shift_in),
    .pwm_out           (pwm_out),
    .period_start_out  (period_start_out),
    .sat_out           (sat_out),
    .overrun_count_out (overrun_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Bench time base: rising edges since reset release
  int unsigned cyc;
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int unsigned w;     // edge index at which the sample becomes pending
    int unsigned duty;
  } samp_t;

  samp_t       log_q[$];
  int unsigned sat_exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic longint clamp_scaled(input int s, input int g);
    longint v;
    v = longint'(s) * (longint'(1) << g);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic int unsigned ref_duty(input int s, input int g);
    return int'((clamp_scaled(s, g) + 32768) / (65536 / PERIOD));
  endfunction

  function automatic bit ref_clip(input int s, input int g);
    longint v;
    v = longint'(s) * (longint'(1) << g);
    return (v > 32767) || (v < -32768);
  endfunction

  // Period p plays the newest sample that became pending strictly before its start edge
  function automatic int unsigned exp_duty(input int unsigned p);
    int unsigned d;
    d = PERIOD / 2;
    foreach (log_q[i]) if (log_q[i].w < p * PERIOD) d = log_q[i].duty;
    return d;
  endfunction

  // A sample is lost if the next one lands before the next period start edge after it
  function automatic int unsigned exp_overruns();
    int unsigned n;
    int unsigned c;
    n = 0;
    for (int i = 0; i + 1 < log_q.size(); i++) begin
      c = (log_q[i].w / PERIOD + 1) * PERIOD;
      if (log_q[i+1].w < c) n++;
    end
    return (n > 255) ? 255 : n;
  endfunction

  // Called at a falling edge; ready_in is high for exactly one cycle
  task automatic send(input int s, input int g);
    samp_t e;
    signal_in     = 16'(s);
    gain_shift_in = 3'(g);
    ready_in      = 1'b1;
    e.w    = cyc + 2;
    e.duty = ref_duty(s, g);
    log_q.push_back(e);
    if (ref_clip(s, g)) sat_exp_q.push_back(cyc + 1);
    @(negedge clk_in);
    ready_in = 1'b0;
  endtask

  task automatic wait_cnt(input int unsigned k);
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk_in);
      if (cyc % PERIOD == k) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_cnt: counter position %0d not reached", k);
  endtask

  task automatic rand_send();
    send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 7)));
  endtask

  // Monitor: period boundaries, per-window high counts, sat pulses
  int unsigned acc = 0;
  always @(negedge clk_in) begin
    if (rst_in) begin
      acc = 0;
    end else begin
      bit sat_exp;
      check("period_start", int'(period_start_out), int'(cyc % PERIOD == 0));
      if (cyc > 0) acc += int'(pwm_out);
      if (cyc > 0 && cyc % PERIOD == 0) begin
        check("period_high_count", int'(acc), int'(exp_duty(cyc / PERIOD - 1)));
        acc = 0;
      end
      sat_exp = (sat_exp_q.size() > 0) && (sat_exp_q[0] == cyc);
      check("sat_out", int'(sat_out), int'(sat_exp));
      if (sat_exp) void'(sat_exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_sat", int'(sat_out), 0);
    check("rst_overrun", int'(overrun_count_out), 0);
    check("rst_period_start", int'(period_start_out), 1);
    @(negedge clk_in);
    rst_in = 1'b0;

    // (a) idle: two periods at mid-scale
    wait_cnt(0);
    wait_cnt(0);

    // (b) full-scale without clipping
    wait_cnt(10);
    send(32767, 0);
    wait_cnt(10);
    send(-32768, 0);
    wait_cnt(10);

    // (c) clipping through gain
    send(4096, 3);
    wait_cnt(10);
    send(-4097, 3);
    wait_cnt(10);
    wait_cnt(10);

    // random samples at random spacing, including overruns and wrap coincidences
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 180)) @(negedge clk_in);
      rand_send();
    end
    repeat (4) @(negedge clk_in);
    check("overrun_random", int'(overrun_count_out), int'(exp_overruns()));

    // (d) overrun within one period
    wait_cnt(0);
    wait_cnt(10);
    send(0, 0);
    wait_cnt(100);
    send(16384, 0);
    repeat (4) @(negedge clk_in);
    check("overrun_d", int'(overrun_count_out), int'(exp_overruns()));
    check("duty_d_model", int'(log_q[log_q.size()-1].duty), 192);
    wait_cnt(0);
    wait_cnt(0);

    // (e) stage-2 write on the wrap edge
    wait_cnt(10);
    send(-16384, 0);
    wait_cnt(254);
    send(8192, 0);
    repeat (4) @(negedge clk_in);
    check("overrun_e", int'(overrun_count_out), int'(exp_overruns()));
    wait_cnt(0);
    wait_cnt(0);
    wait_cnt(0);

    // (f) async reset mid-period at full duty
    wait_cnt(10);
    send(32767, 0);
    wait_cnt(0);
    wait_cnt(77);
    check("pwm_before_reset", int'(pwm_out), 1);
    #2;
    rst_in = 1'b1;
    #1;
    check("pwm_async_reset", int'(pwm_out), 0);
    check("period_start_async_reset", int'(period_start_out), 1);
    log_q.delete();
    sat_exp_q.delete();
    @(negedge clk_in);
    signal_in = 16'h7FFF;
    ready_in  = 1'b1;
    @(negedge clk_in);
    ready_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < 310; i++) rand_send();
    repeat (4) @(negedge clk_in);
    check("overrun_model_sat", int'(overrun_count_out), int'(exp_overruns()));
    check("overrun_saturated", int'(overrun_count_out), 255);
    wait_cnt(0);
    wait_cnt(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
